// File: rtl/dump_controller.sv
// dump_controller: streams a PC/register/memory dump frame, MSB byte first, over a byte handshake.
// Ports: i_clock/i_reset (sync, active-high); i_trigger starts a frame from IDLE;
//   i_pc/i_reg/i_mem are the word sources, with i_reg/i_mem valid one cycle after o_reg_addr/o_mem_addr;
//   o_tx_valid/o_tx_byte/i_tx_ready form the byte handshake; o_reg_sel/o_mem_sel flag the section being read;
//   o_hold freezes the pipeline during a dump; o_done pulses once when the frame completes.
// Option: define DUMP_HEADER_EN to prefix each frame with the sync byte 0xA5.
module dump_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int NREGS          = 32,
  parameter int MEM_WORDS      = 16,
  parameter int MEM_ADDR_WIDTH = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_trigger,
  input  logic [DATA_WIDTH-1:0]     i_pc,
  input  logic [DATA_WIDTH-1:0]     i_reg,
  input  logic [DATA_WIDTH-1:0]     i_mem,
  input  logic                      i_tx_ready,
  output logic                      o_tx_valid,
  output logic [7:0]                o_tx_byte,
  output logic [4:0]                o_reg_addr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_reg_sel,
  output logic                      o_mem_sel,
  output logic                      o_hold,
  output logic                      o_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int IMAX = NREGS > MEM_WORDS ? NREGS : MEM_WORDS;
  localparam int IW = $clog2(IMAX) < 1 ? 1 : $clog2(IMAX);
  localparam logic [DATA_WIDTH-1:0] HDR_WORD = DATA_WIDTH'(8'hA5) << (DATA_WIDTH - 8);
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, SEND, DONE} state_t;
  typedef enum logic [1:0] {SEC_HDR, SEC_PC, SEC_REG, SEC_MEM} sec_t;
`ifdef DUMP_HEADER_EN
  localparam sec_t FIRST = SEC_HDR;
`else
  localparam sec_t FIRST = SEC_PC;
`endif
  state_t state;
  sec_t sec, nsec;
  logic [IW-1:0] idx, nidx;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic last_reg, last_mem, fin;
  assign o_tx_byte = sh[DATA_WIDTH-1 -: 8];
  always_comb begin
    last_reg = idx == IW'(NREGS - 1);
    last_mem = idx == IW'(MEM_WORDS - 1);
    fin = sec == SEC_MEM && last_mem;
    nsec = sec == SEC_HDR ? SEC_PC :
           sec == SEC_PC ? SEC_REG :
           (sec == SEC_REG && !last_reg) ? SEC_REG : SEC_MEM;
    nidx = ((sec == SEC_REG && !last_reg) || (sec == SEC_MEM && !last_mem)) ? idx + 1'b1 : '0;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      sec <= FIRST;
      idx <= '0;
      cnt <= '0;
      sh <= '0;
      o_tx_valid <= 1'b0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
      o_reg_sel <= 1'b0;
      o_mem_sel <= 1'b0;
      o_hold <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_trigger) begin
          state <= ADDR;
          sec <= FIRST;
          idx <= '0;
          o_hold <= 1'b1;
        end
        // Header and PC need no read latency, so they load straight into the shifter.
        ADDR: if (sec == SEC_REG || sec == SEC_MEM) state <= LATCH;
        else begin
          sh <= sec == SEC_PC ? i_pc : HDR_WORD;
          cnt <= sec == SEC_PC ? CW'(NB) : CW'(1);
          o_tx_valid <= 1'b1;
          state <= SEND;
        end
        LATCH: begin
          sh <= o_reg_sel ? i_reg : i_mem;
          cnt <= CW'(NB);
          o_reg_sel <= 1'b0;
          o_mem_sel <= 1'b0;
          o_tx_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (i_tx_ready) begin
          sh <= sh << 8;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_tx_valid <= 1'b0;
            state <= fin ? DONE : ADDR;
            o_done <= fin;
            sec <= nsec;
            idx <= nidx;
            o_reg_sel <= nsec == SEC_REG;
            o_mem_sel <= nsec == SEC_MEM && !fin;
            o_reg_addr <= nsec == SEC_REG ? 5'(nidx) : o_reg_addr;
            o_mem_addr <= (nsec == SEC_MEM && !fin) ? MEM_ADDR_WIDTH'(nidx) : o_mem_addr;
          end
        end
        DONE: begin
          o_hold <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dump_controller.md
DUMP_CONTROLLER -- requirements
Module: dump_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32: datapath word width; SHALL be a multiple of 8.
REQ-002 Parameter NREGS, default 32: number of register-file words dumped.
REQ-003 Parameter MEM_WORDS, default 16: number of data-memory words dumped.
REQ-004 Parameter MEM_ADDR_WIDTH, default 4: width of o_mem_addr; 2^MEM_ADDR_WIDTH SHALL be >= MEM_WORDS.
REQ-005 i_clock  in  1: single clock; all state changes on rising edge.
REQ-006 i_reset  in  1: synchronous, active-high reset.
REQ-007 i_trigger  in  1: dump request; sampled only in IDLE.
REQ-008 i_pc  in  DATA_WIDTH: current program counter.
REQ-009 i_reg  in  DATA_WIDTH: register-file read data; valid one cycle after o_reg_addr is presented.
REQ-010 i_mem  in  DATA_WIDTH: data-memory read data; valid one cycle after o_mem_addr is presented.
REQ-011 i_tx_ready  in  1: UART transmitter can accept a byte.
REQ-012 o_tx_valid  out  1: o_tx_byte holds a byte to send.
REQ-013 o_tx_byte  out  8: byte to transmit.
REQ-014 o_reg_addr  out  5: register index being read.
REQ-015 o_mem_addr  out  MEM_ADDR_WIDTH: memory word index being read.
REQ-016 o_reg_sel / o_mem_sel  out  1 each: high while register / memory section is being read.
REQ-017 o_hold  out  1: freezes the pipeline (gates start/step) while a dump is in progress.
REQ-018 o_done  out  1: one-cycle pulse when the dump frame is complete.

Function
REQ-019 States: IDLE, ADDR, LATCH, SEND, DONE; encoding free.
REQ-020 IDLE: i_trigger=1 -> ADDR with section=PC, index=0; o_hold rises on the next cycle and stays high through DONE.
REQ-021 Frame order: PC word, then reg 0..NREGS-1, then mem 0..MEM_WORDS-1; each word sent MSB byte first.
REQ-022 ADDR: drive o_reg_addr/o_mem_addr=index for exactly one cycle, then LATCH; PC section skips the wait.
REQ-023 LATCH: capture i_pc, i_reg or i_mem into a DATA_WIDTH-bit shift register, byte count=DATA_WIDTH/8, then SEND.
REQ-024 SEND: o_tx_valid=1, o_tx_byte=shift register MSB byte; o_tx_byte SHALL stay stable until accepted.
REQ-025 A byte is accepted when o_tx_valid & i_tx_ready in the same cycle; on acceptance shift left 8 and decrement count.
REQ-026 Last byte of a word accepted: advance index/section and go to ADDR, or to DONE after mem word MEM_WORDS-1.
REQ-027 o_tx_valid SHALL deassert for at least one cycle between words (ADDR/LATCH); back-to-back bytes within a word allowed.
REQ-028 DONE: o_done=1 for one cycle, o_hold=0 from the next cycle, return to IDLE.
REQ-029 i_trigger while not IDLE SHALL be ignored; no queuing.
REQ-030 i_tx_ready held low stalls SEND indefinitely with no byte loss or duplication.
REQ-031 Index counters SHALL not wrap: the last reg index is NREGS-1, the last mem index is MEM_WORDS-1.
REQ-032 Default frame length: 4+128+64 = 196 bytes.

Reset
REQ-033 On i_reset=1: state=IDLE; o_tx_valid, o_hold, o_done, o_reg_sel, o_mem_sel=0; o_tx_byte, o_reg_addr, o_mem_addr=0.
REQ-034 Reset mid-dump SHALL abort the frame; o_tx_valid=0 in the cycle after reset is sampled; no o_done pulse.

Configuration
REQ-035 Macro DUMP_HEADER_EN defined: each frame is prefixed by the sync byte 0xA5, sent under the same handshake before the PC word (frame = 197 bytes by default).
REQ-036 Macro DUMP_HEADER_EN undefined: no header; the first byte is PC[31:24].

Verification
REQ-037 PC=0x0040_0010, i_tx_ready=1, trigger pulse -> first 4 bytes 00 40 00 10, then reg0 bytes; o_done after 196 accepts.
REQ-038 Reg r5=0xDEADBEEF -> bytes 24..27 of the frame = DE AD BE EF; o_reg_addr=5 one cycle before capture.
REQ-039 i_tx_ready toggling at random during SEND -> o_tx_byte stable while valid&!ready; 196 unique bytes received in order.
REQ-040 Second trigger at byte 50 -> ignored; exactly one frame and one o_done pulse.
REQ-041 i_reset asserted at byte 100 -> o_tx_valid=0 next cycle, o_hold=0, no o_done; new trigger restarts at PC byte 0.
REQ-042 With DUMP_HEADER_EN defined -> first byte 0xA5, total 197 bytes; without it -> 196.
